// File: rtl/store_serializer_pkg.sv
// Shared definitions for the store serializer: size encodings, FSM states
// and small helpers for lane count and alignment legality.
package store_serializer_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERR   = 2'd3
    } state_e;

    // Index of the last byte of an access (N-1); illegal size maps to 0.
    function automatic logic [1:0] last_idx(input logic [1:0] size);
        case (size)
            SZ_HALF: last_idx = 2'd1;
            SZ_WORD: last_idx = 2'd3;
            default: last_idx = 2'd0;
        endcase
    endfunction

    // Illegal size, or an address not aligned to the access size.
    function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: is_illegal = 1'b0;
            SZ_HALF: is_illegal = addr_lo[0];
            SZ_WORD: is_illegal = (addr_lo != 2'b00);
            default: is_illegal = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/store_byte_select.sv
// Big-endian lane selector: returns byte k of an N-byte access, where byte 0
// is the most significant byte of the access.
//   data_i       register value
//   size_i       access size encoding
//   k_i          byte index within the access
//   sel_byte_c_o selected byte (combinational)
module store_byte_select
    import store_serializer_pkg::*;
(
    input  logic [DATA_W-1:0] data_i,
    input  logic [1:0]        size_i,
    input  logic [1:0]        k_i,
    output logic [BYTE_W-1:0] sel_byte_c_o
);

    logic [1:0] lane;

    // Lane number counted from the least significant byte.
    always_comb begin
        lane         = last_idx(size_i) - k_i;
        sel_byte_c_o = data_i[BYTE_W*lane +: BYTE_W];
    end

endmodule

// File: rtl/store_serializer.sv
// Store serializer: narrows a 32-bit store into big-endian bytes written one
// per handshake to a byte-wide memory port. Flags misaligned/illegal requests
// and per-byte memory timeouts.
//   CLK, Reset            clock, synchronous active-low reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_addr/data/size    store request
//   mem_we/addr/wdata     byte write to memory, held until mem_ack
//   mem_ack               memory accepts current byte
//   done, err             one-cycle completion / error pulses
module store_serializer
    import store_serializer_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic [1:0]        req_size,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BYTE_W-1:0] mem_wdata,
    input  logic              mem_ack,
    output logic              done,
    output logic              err
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    state_e              state_q, state_d;
    logic [1:0]          k_q, k_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [1:0]          size_q, size_d;

    logic                req_ready_q, req_ready_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [BYTE_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [BYTE_W-1:0]   sel_byte;

    // Lane for the byte that will be on the bus next cycle.
    store_byte_select u_byte_select (
        .data_i       (data_d),
        .size_i       (size_d),
        .k_i          (k_d),
        .sel_byte_c_o (sel_byte)
    );

    // State and registered outputs.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            tmo_q       <= '0;
            base_q      <= '0;
            data_q      <= '0;
            size_q      <= SZ_BYTE;
            req_ready_q <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            tmo_q       <= tmo_d;
            base_q      <= base_d;
            data_q      <= data_d;
            size_q      <= size_d;
            req_ready_q <= req_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Next state; outputs are computed for the cycle after the edge.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        tmo_d       = tmo_q;
        base_d      = base_q;
        data_d      = data_q;
        size_d      = size_q;
        req_ready_d = 1'b0;
        mem_we_d    = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid) begin
                    req_ready_d = 1'b0;
                    if (is_illegal(req_size, req_addr[1:0])) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d  = ST_WRITE;
                        base_d   = req_addr;
                        data_d   = req_data;
                        size_d   = req_size;
                        k_d      = '0;
                        tmo_d    = '0;
                        mem_we_d = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                mem_we_d = 1'b1;
                if (mem_ack) begin
                    tmo_d = '0;
                    if (k_q == last_idx(size_q)) begin
                        state_d  = ST_DONE;
                        mem_we_d = 1'b0;
                        done_d   = 1'b1;
                        k_d      = '0;
                    end else begin
                        k_d = k_q + 2'd1;
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    // Abort; bytes already written stay written.
                    state_d  = ST_ERR;
                    mem_we_d = 1'b0;
                    err_d    = 1'b1;
                    tmo_d    = '0;
                    k_d      = '0;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_DONE, ST_ERR: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
        endcase

        // Bus is zeroed whenever no write is being presented.
        mem_addr_d  = mem_we_d ? (base_d + ADDR_W'(k_d)) : '0;
        mem_wdata_d = mem_we_d ? sel_byte : '0;
    end

    assign req_ready = req_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_store_serializer.sv
// Directed bench for store_serializer: byte/half/word stores, stalls,
// illegal requests, timeout and reset mid-store.
module tb_store_serializer;

    logic        CLK;
    logic        Reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    store_serializer #(
        .ADDR_W  (32),
        .TIMEOUT (16)
    ) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_size  (req_size),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .done      (done),
        .err       (err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory write presented this cycle.
    task automatic exp_write(input string tag, input logic [31:0] a, input logic [7:0] d);
        check({tag, ".we"},    32'(mem_we),    32'd1);
        check({tag, ".addr"},  mem_addr,       a);
        check({tag, ".wdata"}, 32'(mem_wdata), 32'(d));
        check({tag, ".ready"}, 32'(req_ready), 32'd0);
        check({tag, ".done"},  32'(done),      32'd0);
        check({tag, ".err"},   32'(err),       32'd0);
    endtask

    // Quiet outputs with the given pulse values.
    task automatic exp_idle(input string tag, input logic rdy, input logic dn, input logic er);
        check({tag, ".we"},    32'(mem_we),    32'd0);
        check({tag, ".addr"},  mem_addr,       32'd0);
        check({tag, ".wdata"}, 32'(mem_wdata), 32'd0);
        check({tag, ".ready"}, 32'(req_ready), 32'(rdy));
        check({tag, ".done"},  32'(done),      32'(dn));
        check({tag, ".err"},   32'(err),       32'(er));
    endtask

    task automatic request(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_size  = s;
    endtask

    initial begin
        Reset     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        req_size  = 2'b00;
        mem_ack   = 1'b0;

        // Reset state
        repeat (2) @(negedge CLK);
        exp_idle("reset", 1'b1, 1'b0, 1'b0);
        Reset = 1'b1;
        @(negedge CLK);
        exp_idle("post_reset", 1'b1, 1'b0, 1'b0);

        // Byte store, always-ack: 0xDD@0x10, done at T+2
        mem_ack = 1'b1;
        request(32'h10, 32'hAABB_CCDD, 2'b00);
        @(negedge CLK);
        exp_write("byte.b0", 32'h10, 8'hDD);
        req_valid = 1'b0;
        @(negedge CLK);
        exp_idle("byte.done", 1'b0, 1'b1, 1'b0);
        @(negedge CLK);
        exp_idle("byte.back", 1'b1, 1'b0, 1'b0);

        // Half store, first byte stalled two cycles
        mem_ack = 1'b0;
        request(32'h22, 32'h0000_BEEF, 2'b01);
        @(negedge CLK);
        req_valid = 1'b0;
        exp_write("half.b0c1", 32'h22, 8'hBE);
        @(negedge CLK);
        exp_write("half.b0c2", 32'h22, 8'hBE);
        @(negedge CLK);
        exp_write("half.b0c3", 32'h22, 8'hBE);
        mem_ack = 1'b1;
        @(negedge CLK);
        exp_write("half.b1", 32'h23, 8'hEF);
        @(negedge CLK);
        exp_idle("half.done", 1'b0, 1'b1, 1'b0);
        @(negedge CLK);
        exp_idle("half.back", 1'b1, 1'b0, 1'b0);

        // Word store, zero stall: done T+5, ready T+6
        request(32'h100, 32'h1122_3344, 2'b10);
        @(negedge CLK);
        req_valid = 1'b0;
        exp_write("word.b0", 32'h100, 8'h11);
        @(negedge CLK);
        exp_write("word.b1", 32'h101, 8'h22);
        @(negedge CLK);
        exp_write("word.b2", 32'h102, 8'h33);
        @(negedge CLK);
        exp_write("word.b3", 32'h103, 8'h44);
        @(negedge CLK);
        exp_idle("word.done", 1'b0, 1'b1, 1'b0);
        @(negedge CLK);
        exp_idle("word.back", 1'b1, 1'b0, 1'b0);

        // Illegal requests: err pulse, no write
        request(32'h102, 32'hDEAD_BEEF, 2'b10);
        @(negedge CLK);
        req_valid = 1'b0;
        exp_idle("mis_word.err", 1'b0, 1'b0, 1'b1);
        @(negedge CLK);
        exp_idle("mis_word.back", 1'b1, 1'b0, 1'b0);

        request(32'h31, 32'h0000_1234, 2'b01);
        @(negedge CLK);
        req_valid = 1'b0;
        exp_idle("mis_half.err", 1'b0, 1'b0, 1'b1);
        @(negedge CLK);
        exp_idle("mis_half.back", 1'b1, 1'b0, 1'b0);

        request(32'h40, 32'h0000_0055, 2'b11);
        @(negedge CLK);
        req_valid = 1'b0;
        exp_idle("bad_size.err", 1'b0, 1'b0, 1'b1);
        @(negedge CLK);
        exp_idle("bad_size.back", 1'b1, 1'b0, 1'b0);

        // Timeout: 16 cycles of first byte, then err, no done
        mem_ack = 1'b0;
        request(32'h200, 32'h1122_3344, 2'b10);
        @(negedge CLK);
        req_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp_write($sformatf("tmo.c%0d", i), 32'h200, 8'h11);
            @(negedge CLK);
        end
        exp_idle("tmo.err", 1'b0, 1'b0, 1'b1);
        @(negedge CLK);
        exp_idle("tmo.back", 1'b1, 1'b0, 1'b0);

        // Reset after second ack abandons the store silently
        mem_ack = 1'b1;
        request(32'h300, 32'hCAFE_F00D, 2'b10);
        @(negedge CLK);
        req_valid = 1'b0;
        exp_write("rst.b0", 32'h300, 8'hCA);
        @(negedge CLK);
        exp_write("rst.b1", 32'h301, 8'hFE);
        @(negedge CLK);
        exp_write("rst.b2", 32'h302, 8'hF0);
        Reset   = 1'b0;
        mem_ack = 1'b0;
        @(negedge CLK);
        exp_idle("rst.in_reset", 1'b1, 1'b0, 1'b0);
        Reset = 1'b1;
        @(negedge CLK);
        exp_idle("rst.after", 1'b1, 1'b0, 1'b0);

        // Normal byte store after reset
        mem_ack = 1'b1;
        request(32'h44, 32'h0000_005A, 2'b00);
        @(negedge CLK);
        req_valid = 1'b0;
        exp_write("rst.byte", 32'h44, 8'h5A);
        @(negedge CLK);
        exp_idle("rst.byte_done", 1'b0, 1'b1, 1'b0);
        @(negedge CLK);
        exp_idle("rst.byte_back", 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
